// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Multi-cycle restoring integer divider, BPC quotient bits per
//            cycle, valid/ready on both sides, divide-by-zero reporting.
//            Optional signed mode enabled by defining DIV_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
   parameter int N   = 64,
   parameter int M   = 64,
   parameter int BPC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_signed,
   input  logic [N-1:0] dividend,
   input  logic [M-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [M-1:0] remainder,
   output logic         dbz,
   output logic         ovf,
   output logic         busy
);

   localparam int ITER = N / BPC;
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   dvd;        // unretired dividend bits; quotient bits enter at the LSB
   logic [M-1:0]   rem;        // partial remainder, always < divisor between steps
   logic [M-1:0]   dvs;        // divisor magnitude
   logic [M-1:0]   dvd_lo;     // raw dividend low bits, returned on divide-by-zero
   logic           zero_dvs;

   logic [N-1:0]   ld_dvd;
   logic [M-1:0]   ld_dvs;
   logic [M:0]     step_pr;    // one bit wider so the compare never truncates
   logic [N-1:0]   step_dvd;
   logic [M-1:0]   step_rem;
   logic [N-1:0]   fix_q;
   logic [M-1:0]   fix_r;
   logic           fix_ovf;

`ifdef DIV_SIGNED_EN
   logic           neg_q;
   logic           neg_r;
   logic           is_ovf;
   logic           ld_sd;
   logic           ld_sv;
   logic           ld_ovf;

   // Operand signs and magnitudes; -2^(N-1) keeps its pattern, which is the correct unsigned magnitude
   always_comb begin
      ld_sd  = in_signed & dividend[N-1];
      ld_sv  = in_signed & divisor[M-1];
      ld_dvd = ld_sd ? -dividend : dividend;
      ld_dvs = ld_sv ? -divisor  : divisor;
      ld_ovf = in_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (&divisor);
   end
`else
   logic           unused_signed;
   assign unused_signed = in_signed;

   // Unsigned build: operands go straight into the datapath
   always_comb begin
      ld_dvd = dividend;
      ld_dvs = divisor;
   end
`endif

   // BPC chained restoring steps per CALC cycle
   always_comb begin
      step_pr  = '0;
      step_dvd = dvd;
      step_rem = rem;
      for (int b = 0; b < BPC; b++) begin
         step_pr  = {step_rem, step_dvd[N-1]};
         step_dvd = {step_dvd[N-2:0], 1'b0};
         if (step_pr >= {1'b0, dvs}) begin
            step_pr     = step_pr - {1'b0, dvs};
            step_dvd[0] = 1'b1;
         end
         step_rem = step_pr[M-1:0];
      end
   end

   // Final result: sign correction, then overflow and divide-by-zero overrides
   always_comb begin
      fix_q   = dvd;
      fix_r   = rem;
      fix_ovf = 1'b0;
`ifdef DIV_SIGNED_EN
      if (neg_q) fix_q = -dvd;
      if (neg_r) fix_r = -rem;
      if (is_ovf) begin
         fix_q   = {1'b1, {(N-1){1'b0}}};
         fix_r   = '0;
         fix_ovf = 1'b1;
      end
`endif
      if (zero_dvs) begin
         fix_q   = '1;
         fix_r   = dvd_lo;
         fix_ovf = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = CALC;
         end
         CALC: if (cnt == CW'(ITER - 1)) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand load, iteration, result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         dvd       <= '0;
         rem       <= '0;
         dvs       <= '0;
         dvd_lo    <= '0;
         zero_dvs  <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         is_ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               cnt      <= '0;
               dvd      <= ld_dvd;
               dvs      <= ld_dvs;
               rem      <= '0;
               dvd_lo   <= dividend[M-1:0];
               zero_dvs <= (divisor == '0);
               dbz      <= 1'b0;
               ovf      <= 1'b0;
`ifdef DIV_SIGNED_EN
               neg_q    <= ld_sd ^ ld_sv;
               neg_r    <= ld_sd;
               is_ovf   <= ld_ovf;
`endif
            end
            CALC: begin
               dvd <= step_dvd;
               rem <= step_rem;
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               quotient  <= fix_q;
               remainder <= fix_r;
               dbz       <= zero_dvs;
               ovf       <= fix_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seq_divider
// Brief    : Self-checking bench; three divider instances (BPC 1, 2, 8) on
//            shared stimulus, N = M = 8. Signed expectations follow
//            DIV_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

`ifdef DIV_SIGNED_EN
   localparam bit SG = 1'b1;
`else
   localparam bit SG = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_signed = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] dividend = '0;
   logic [7:0] divisor = '0;
   logic       in_ready [3];
   logic       out_valid[3];
   logic       dbz      [3];
   logic       ovf      [3];
   logic       busy     [3];
   logic [7:0] quotient [3];
   logic [7:0] remainder[3];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       s;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
      logic       o;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   exp_lat[3] = '{9, 5, 2};
   int   bpc_of[3]  = '{1, 2, 8};
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   seq_divider #(.N(8), .M(8), .BPC(1)) u_bpc1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid[0]), .out_ready(out_ready), .quotient(quotient[0]),
      .remainder(remainder[0]), .dbz(dbz[0]), .ovf(ovf[0]), .busy(busy[0]));

   seq_divider #(.N(8), .M(8), .BPC(2)) u_bpc2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid[1]), .out_ready(out_ready), .quotient(quotient[1]),
      .remainder(remainder[1]), .dbz(dbz[1]), .ovf(ovf[1]), .busy(busy[1]));

   seq_divider #(.N(8), .M(8), .BPC(8)) u_bpc8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
      .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid[2]), .out_ready(out_ready), .quotient(quotient[2]),
      .remainder(remainder[2]), .dbz(dbz[2]), .ovf(ovf[2]), .busy(busy[2]));

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (BPC=%0d): got %0h want %0h at %0t", name, bpc_of[idx], act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] q, input logic [7:0] r, input logic z, input logic o);
      vec_t v;
      v.a = a; v.b = b; v.s = s; v.q = q; v.r = r; v.z = z; v.o = o;
      tbl.push_back(v);
   endtask

   task automatic chk_result(input int i, input vec_t e);
      chk("quotient",  i, 32'(quotient[i]),  32'(e.q));
      chk("remainder", i, 32'(remainder[i]), 32'(e.r));
      chk("dbz",       i, 32'(dbz[i]),       32'(e.z));
      chk("ovf",       i, 32'(ovf[i]),       32'(e.o));
   endtask

   task automatic chk_reset_state(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_in_ready"},  i, 32'(in_ready[i]),  32'd1);
         chk({tag, "_out_valid"}, i, 32'(out_valid[i]), 32'd0);
         chk({tag, "_quotient"},  i, 32'(quotient[i]),  32'd0);
         chk({tag, "_remainder"}, i, 32'(remainder[i]), 32'd0);
         chk({tag, "_dbz"},       i, 32'(dbz[i]),       32'd0);
         chk({tag, "_ovf"},       i, 32'(ovf[i]),       32'd0);
         chk({tag, "_busy"},      i, 32'(busy[i]),      32'd0);
      end
   endtask

   // One operation with out_ready high; checks latency and results on all instances
   task automatic run_op(input vec_t v);
      int   lat[3];
      vec_t e;
      lat = '{0, 0, 0};
      chk("idle_in_ready", 1, 32'(in_ready[1]), 32'd1);
      dividend  = v.a;
      divisor   = v.b;
      in_signed = v.s;
      in_valid  = 1'b1;
      sb.push_back(v);
      tick();
      in_valid  = 1'b0;
      dividend  = 8'($urandom);
      divisor   = 8'($urandom);
      in_signed = 1'($urandom);
      for (int c = 1; c <= 12; c++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            if (out_valid[i] && lat[i] == 0) begin
               lat[i] = c;
               if (i == 1) e = sb.pop_front();
               else        e = v;
               chk("latency", i, 32'(c), 32'(exp_lat[i]));
               chk_result(i, e);
            end
         end
         if (lat[1] == 0) chk("in_ready_busy", 1, 32'(in_ready[1]), 32'd0);
      end
      for (int i = 0; i < 3; i++) begin
         if (lat[i] == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout (BPC=%0d): out_valid never rose, want latency %0d", bpc_of[i], exp_lat[i]);
         end
      end
   endtask

   initial begin
      vec_t bp;
      vec_t e;
      bit   all_valid;

      // a, b, signed, q, r, dbz, ovf
      add(8'd100, 8'd7,  1'b0, 8'd14,  8'd2,  1'b0, 1'b0);
      add(8'hA5,  8'h00, 1'b0, 8'hFF,  8'hA5, 1'b1, 1'b0);
      add(8'hF9,  8'h02, 1'b1, SG ? 8'hFD : 8'h7C, SG ? 8'hFF : 8'h01, 1'b0, 1'b0);
      add(8'h07,  8'hFE, 1'b1, SG ? 8'hFD : 8'h00, SG ? 8'h01 : 8'h07, 1'b0, 1'b0);
      add(8'h80,  8'hFF, 1'b1, SG ? 8'h80 : 8'h00, SG ? 8'h00 : 8'h80, 1'b0, SG);
      add(8'h80,  8'hFF, 1'b0, 8'h00,  8'h80, 1'b0, 1'b0);
      add(8'd255, 8'd16, 1'b0, 8'd15,  8'd15, 1'b0, 1'b0);
      add(8'd255, 8'd1,  1'b0, 8'hFF,  8'h00, 1'b0, 1'b0);
      add(8'd0,   8'd5,  1'b0, 8'h00,  8'h00, 1'b0, 1'b0);
      add(8'd200, 8'd200,1'b0, 8'h01,  8'h00, 1'b0, 1'b0);
      add(8'h80,  8'h00, 1'b1, 8'hFF,  8'h80, 1'b1, 1'b0);
      add(8'h80,  8'h02, 1'b1, SG ? 8'hC0 : 8'h40, 8'h00, 1'b0, 1'b0);
      add(8'h9C,  8'hF9, 1'b1, SG ? 8'h0E : 8'h00, SG ? 8'hFE : 8'h9C, 1'b0, 1'b0);
      add(8'hFF,  8'hFF, 1'b0, 8'h01,  8'h00, 1'b0, 1'b0);

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      chk_reset_state("reset");
      rst = 1'b0;
      tick();

      // Table-driven operations
      for (int k = 0; k < tbl.size(); k++) run_op(tbl[k]);

      // Backpressure: results hold and new requests are ignored while out_ready is low
      out_ready = 1'b0;
      bp.a = 8'd100; bp.b = 8'd7; bp.s = 1'b0; bp.q = 8'd14; bp.r = 8'd2; bp.z = 1'b0; bp.o = 1'b0;
      dividend = bp.a; divisor = bp.b; in_signed = bp.s; in_valid = 1'b1;
      sb.push_back(bp);
      tick();
      in_valid = 1'b0;
      all_valid = 1'b0;
      for (int c = 1; c <= 12 && !all_valid; c++) begin
         tick();
         all_valid = out_valid[0] && out_valid[1] && out_valid[2];
      end
      if (!all_valid) begin
         n_vec++;
         n_bad++;
         $display("FAIL bp_timeout: out_valid not high on all instances");
      end
      e = sb.pop_front();
      chk_result(1, e);
      dividend = 8'h33; divisor = 8'h03; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", i, 32'(out_valid[i]), 32'd1);
            chk("bp_in_ready",  i, 32'(in_ready[i]),  32'd0);
            chk_result(i, bp);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("bp_release_out_valid", i, 32'(out_valid[i]), 32'd0);
         chk("bp_release_in_ready",  i, 32'(in_ready[i]),  32'd1);
      end
      bp.a = 8'd255; bp.b = 8'd16; bp.q = 8'd15; bp.r = 8'd15;
      run_op(bp);

      // Reset during the second CALC cycle aborts the operation
      dividend = 8'd100; divisor = 8'd7; in_signed = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk_reset_state("midrst");
      rst = 1'b0;
      tick();
      bp.a = 8'd200; bp.b = 8'd9; bp.q = 8'd22; bp.r = 8'd2;
      run_op(bp);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
